// File: rtl/operand_fetch_unit.sv
// Operand fetch stage: register-file read with write-back bypass, a busy-register
// scoreboard for read-after-write stalls, and a one-entry output register to the ALU.
module operand_fetch_unit #(
  parameter int DW   = 8,
  parameter int AW   = 2,
  parameter int NREG = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_src1,
  input  logic [AW-1:0] in_src2,
  input  logic [AW-1:0] in_dst,
  input  logic          in_wr,
  output logic [AW-1:0] rf_src1,
  output logic [AW-1:0] rf_src2,
  input  logic [DW-1:0] rf_op1,
  input  logic [DW-1:0] rf_op2,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_dst,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [AW-1:0] out_dst,
  output logic          out_wr
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state, state_next;
  logic [NREG-1:0] busy, busy_next;
  logic            byp1, byp2, hazard, accept;

  assign rf_src1 = in_src1;
  assign rf_src2 = in_src2;

  // A same-cycle write-back both resolves the hazard and supplies the operand.
  assign byp1   = wb_valid && (wb_dst == in_src1);
  assign byp2   = wb_valid && (wb_dst == in_src2);
  assign hazard = (busy[in_src1] & ~byp1) | (busy[in_src2] & ~byp2);

  assign out_valid = (state == FULL);
  assign in_ready  = (~out_valid | out_ready) & ~hazard;
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (out_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Set is applied after clear so an issuing writer wins over a retiring one.
  always_comb begin
    busy_next = busy;
    if (wb_valid)       busy_next[wb_dst] = 1'b0;
    if (accept && in_wr) busy_next[in_dst] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_a   <= '0;
      out_b   <= '0;
      out_dst <= '0;
      out_wr  <= 1'b0;
    end else if (accept) begin
      out_a   <= byp1 ? wb_data : rf_op1;
      out_b   <= byp2 ? wb_data : rf_op2;
      out_dst <= in_dst;
      out_wr  <= in_wr;
    end
  end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit: a vector table for per-cycle behaviour
// plus hand-written sequences for backpressure, streaming and async reset.
module tb_operand_fetch_unit;

  logic       clk, rst;
  logic       in_valid, in_ready, in_wr;
  logic [1:0] in_src1, in_src2, in_dst;
  logic [1:0] rf_src1, rf_src2;
  logic [7:0] rf_op1, rf_op2;
  logic       wb_valid;
  logic [1:0] wb_dst;
  logic [7:0] wb_data;
  logic       out_valid, out_ready, out_wr;
  logic [7:0] out_a, out_b;
  logic [1:0] out_dst;

  int n_checks = 0;
  int n_fail   = 0;

  // Register file model: combinational read, written by write-back at the edge.
  logic [7:0] rf [4] = '{8'd10, 8'd11, 8'd31, 8'd41};
  assign rf_op1 = rf[rf_src1];
  assign rf_op2 = rf[rf_src2];
  always @(posedge clk) if (wb_valid) rf[wb_dst] <= wb_data;

  operand_fetch_unit #(.DW(8), .AW(2), .NREG(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst), .in_wr(in_wr),
    .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_op1(rf_op1), .rf_op2(rf_op2),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_dst(out_dst), .out_wr(out_wr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       iv;
    logic [1:0] s1, s2, dst;
    logic       wr;
    logic       wbv;
    logic [1:0] wbd;
    logic [7:0] wbdata;
    logic       ordy;
    logic       exp_rdy, exp_ov;
    logic [7:0] exp_a, exp_b;
    logic [1:0] exp_dst;
    logic       exp_wr;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input int iv, s1, s2, dst, wr, wbv, wbd, wbdata, ordy,
                              exp_rdy, exp_ov, exp_a, exp_b, exp_dst, exp_wr);
    vec_t v;
    v.iv = 1'(iv);   v.s1 = 2'(s1);   v.s2 = 2'(s2);   v.dst = 2'(dst);
    v.wr = 1'(wr);   v.wbv = 1'(wbv); v.wbd = 2'(wbd); v.wbdata = 8'(wbdata);
    v.ordy = 1'(ordy);
    v.exp_rdy = 1'(exp_rdy); v.exp_ov = 1'(exp_ov);
    v.exp_a = 8'(exp_a); v.exp_b = 8'(exp_b);
    v.exp_dst = 2'(exp_dst); v.exp_wr = 1'(exp_wr);
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    in_valid = v.iv;  in_src1 = v.s1; in_src2 = v.s2; in_dst = v.dst; in_wr = v.wr;
    wb_valid = v.wbv; wb_dst = v.wbd; wb_data = v.wbdata;
    out_ready = v.ordy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOuts(input string tag, input logic ov, input logic [7:0] a, b,
                           input logic [1:0] d, input logic w);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(ov));
    checkOutput({tag, " out_a"},     32'(out_a),     32'(a));
    checkOutput({tag, " out_b"},     32'(out_b),     32'(b));
    checkOutput({tag, " out_dst"},   32'(out_dst),   32'(d));
    checkOutput({tag, " out_wr"},    32'(out_wr),    32'(w));
  endtask

  initial begin
    // iv s1 s2 dst wr | wbv wbd wbdata | ordy | rdy ov a b dst wr
    vecs[0]  = mk(1, 2, 3, 0, 0,  0, 0,  0, 1,  1, 1, 31, 41, 0, 0);
    vecs[1]  = mk(1, 0, 0, 1, 1,  0, 0,  0, 1,  1, 1, 10, 10, 1, 1);
    vecs[2]  = mk(1, 1, 2, 3, 0,  0, 0,  0, 1,  0, 0, 10, 10, 1, 1);
    vecs[3]  = mk(1, 1, 2, 3, 0,  1, 1, 21, 1,  1, 1, 21, 31, 3, 0);
    vecs[4]  = mk(1, 1, 1, 2, 0,  0, 0,  0, 1,  1, 1, 21, 21, 2, 0);
    vecs[5]  = mk(1, 0, 3, 0, 0,  1, 0, 55, 1,  1, 1, 55, 41, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0,  0, 0,  0, 1,  1, 0, 55, 41, 0, 0);
    vecs[7]  = mk(1, 3, 3, 3, 1,  0, 0,  0, 1,  1, 1, 41, 41, 3, 1);
    vecs[8]  = mk(1, 3, 0, 2, 1,  1, 3, 77, 1,  1, 1, 77, 55, 2, 1);
    vecs[9]  = mk(1, 0, 0, 2, 1,  1, 2, 99, 1,  1, 1, 55, 55, 2, 1);
    vecs[10] = mk(1, 2, 0, 1, 0,  0, 0,  0, 1,  0, 0, 55, 55, 2, 1);
    vecs[11] = mk(1, 2, 0, 1, 0,  0, 0,  0, 1,  0, 0, 55, 55, 2, 1);
    vecs[12] = mk(1, 2, 0, 1, 0,  1, 2, 12, 1,  1, 1, 12, 55, 1, 0);

    rst = 1'b0;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    #2;
    checkOuts("reset", 1'b0, 8'd0, 8'd0, 2'd0, 1'b0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      checkOuts($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_a, vecs[i].exp_b,
                vecs[i].exp_dst, vecs[i].exp_wr);
    end

    // Backpressure: held operand must stay put while the next instruction waits.
    @(negedge clk);
    applyStimulus(mk(1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      checkOuts($sformatf("bp%0d", c), 1'b1, 8'd12, 8'd55, 2'd1, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOuts("bp release", 1'b1, 8'd55, 8'd77, 2'd1, 1'b0);

    // Streaming: four independent fetches, one result per cycle.
    begin
      logic [1:0] s1q [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
      logic [1:0] s2q [4] = '{2'd1, 2'd3, 2'd0, 2'd2};
      logic [7:0] aq  [4] = '{8'd55, 8'd12, 8'd21, 8'd77};
      logic [7:0] bq  [4] = '{8'd21, 8'd77, 8'd55, 8'd12};
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        in_valid = 1'b1; in_src1 = s1q[k]; in_src2 = s2q[k]; in_dst = 2'(k); in_wr = 1'b0;
        #1;
        checkOutput($sformatf("b2b%0d in_ready", k), 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOuts($sformatf("b2b%0d", k), 1'b1, aq[k], bq[k], 2'(k), 1'b0);
      end
    end

    // Async reset while FULL with a pending writer: must clear without a clock edge.
    @(negedge clk);
    applyStimulus(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    checkOutput("pre-reset out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_src1 = 2'd1; in_src2 = 2'd1;
    #1;
    checkOutput("pre-reset in_ready", 32'(in_ready), 32'd0);
    #1;
    rst = 1'b0;
    #1;
    checkOuts("async reset", 1'b0, 8'd0, 8'd0, 2'd0, 1'b0);
    checkOutput("async reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1; in_dst = 2'd0; in_wr = 1'b0; out_ready = 1'b1;
    #1;
    checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOuts("post-reset", 1'b1, 8'd21, 8'd21, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
